// File: rtl/lc3_pkg.sv
// Shared constants and types for the LC-3 memory unit.
package lc3_pkg;

    // Memory-mapped I/O register addresses
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lc3_mmio.sv
// Keyboard and display registers with their handshakes, plus the MMIO read mux.
module lc3_mmio
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,       // latched access address
    input  logic [15:0] wdata,      // latched access write data
    input  logic        acc,        // access happens on this edge
    input  logic        we,         // access is a write
    output logic [15:0] rdata,      // MMIO read value for addr
    input  logic [7:0]  kbData,
    input  logic        kbStrobe,
    output logic [7:0]  dispData,
    output logic        dispValid,
    input  logic        dispReady
);

    logic [7:0] kb_reg;
    logic       kb_ready;
    logic       kbdr_rd;
    logic       ddr_wr;

    assign kbdr_rd = acc && !we && (addr == KBDR_ADDR);
    assign ddr_wr  = acc &&  we && (addr == DDR_ADDR);

    // Keyboard: a new strobe wins over a KBDR read on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kb_reg   <= 8'h00;
            kb_ready <= 1'b0;
        end else if (kbStrobe) begin
            kb_reg   <= kbData;
            kb_ready <= 1'b1;
        end else if (kbdr_rd) begin
            kb_ready <= 1'b0;
        end
    end

    // Display: a DDR write wins over the consumer handshake on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dispData  <= 8'h00;
            dispValid <= 1'b0;
        end else if (ddr_wr) begin
            dispData  <= wdata[7:0];
            dispValid <= 1'b1;
        end else if (dispValid && dispReady) begin
            dispValid <= 1'b0;
        end
    end

    // MMIO read mux; unmapped addresses read as zero
    always_comb begin
        rdata = 16'h0000;
        case (addr)
            KBSR_ADDR: rdata = {kb_ready, 15'b0};
            KBDR_ADDR: rdata = {8'h00, kb_reg};
            DSR_ADDR:  rdata = {~dispValid, 15'b0};
            DDR_ADDR:  rdata = {8'h00, dispData};
            default:   rdata = 16'h0000;
        endcase
    end

endmodule

// File: rtl/lc3_memory_unit.sv
// LC-3 memory responder: MAR/MDR, word RAM, access FSM and MMIO.
// Handshake: memEN is a request sampled only in IDLE; R is a one-cycle
// completion pulse in DONE; no further request is accepted until IDLE.
// Display: dispValid/dispReady transfer dispData on any edge where both are 1.
module lc3_memory_unit
    import lc3_pkg::*;
#(
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bus,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memEN,
    input  logic        memWE,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic        R,
    input  logic [7:0]  kbData,
    input  logic        kbStrobe,
    output logic [7:0]  dispData,
    output logic        dispValid,
    input  logic        dispReady,
    output state_e      dbg_state
);

    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [15:0]   mem [MEM_DEPTH];
    state_e        state, state_nx;
    logic [3:0]    cnt;
    logic [15:0]   acc_addr;
    logic [15:0]   acc_wdata;
    logic          acc_we;
    logic          acc_fire;
    logic          in_ram;
    logic [AW-1:0] ram_idx;
    logic [15:0]   mmio_rdata;
    logic [15:0]   rd_mux;
    logic [15:0]   rd_data;

    assign in_ram    = {1'b0, acc_addr} < DEPTH_LIM;
    assign ram_idx   = acc_addr[AW-1:0];
    assign rd_mux    = in_ram ? mem[ram_idx] : mmio_rdata;
    assign dbg_state = state;

    // MAR/MDR loads are honoured in every FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MAR <= 16'h0000;
            MDR <= 16'h0000;
        end else begin
            if (ldMAR) MAR <= bus;
            if (ldMDR) MDR <= selMDR ? rd_data : bus;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state; the access is performed on the WAIT->DONE edge
    always_comb begin
        state_nx = state;
        acc_fire = 1'b0;
        R        = 1'b0;
        case (state)
            IDLE: if (memEN) state_nx = WAIT;
            WAIT: if (cnt == 4'd0) begin
                state_nx = DONE;
                acc_fire = 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
                R        = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Snapshot the request on acceptance so later MAR/MDR changes are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= 4'd0;
            acc_addr  <= 16'h0000;
            acc_wdata <= 16'h0000;
            acc_we    <= 1'b0;
        end else if (state == IDLE && memEN) begin
            cnt       <= WAIT_INIT;
            acc_addr  <= MAR;
            acc_wdata <= MDR;
            acc_we    <= memWE;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // RAM write commits on the edge that raises R; contents are not reset
    always_ff @(posedge clk) begin
        if (acc_fire && acc_we && in_ram) mem[ram_idx] <= acc_wdata;
    end

    // Read data captured on the access edge and held until the next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 rd_data <= 16'h0000;
        else if (acc_fire && !acc_we) rd_data <= rd_mux;
    end

    lc3_mmio u_mmio (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (acc_addr),
        .wdata     (acc_wdata),
        .acc       (acc_fire),
        .we        (acc_we),
        .rdata     (mmio_rdata),
        .kbData    (kbData),
        .kbStrobe  (kbStrobe),
        .dispData  (dispData),
        .dispValid (dispValid),
        .dispReady (dispReady)
    );

endmodule

// File: tb/tb_lc3_memory_unit.sv
// Bench for lc3_memory_unit: directed accesses, R latency and read data scoreboard.
module tb_lc3_memory_unit;
  import lc3_pkg::*;

  localparam int W = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bus = 16'h0000;
  logic        ldMAR = 1'b0, ldMDR = 1'b0, selMDR = 1'b0;
  logic        memEN = 1'b0, memWE = 1'b0;
  logic [7:0]  kbData = 8'h00;
  logic        kbStrobe = 1'b0;
  logic        dispReady = 1'b0;
  logic [15:0] MAR, MDR;
  logic        R;
  logic [7:0]  dispData;
  logic        dispValid;
  state_e      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  lc3_memory_unit #(.MEM_DEPTH(4096), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .selMDR(selMDR), .memEN(memEN), .memWE(memWE), .MAR(MAR), .MDR(MDR), .R(R),
    .kbData(kbData), .kbStrobe(kbStrobe), .dispData(dispData),
    .dispValid(dispValid), .dispReady(dispReady), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  // entry: {expected R cycle[31:0], is_read, expected read data[15:0]}
  logic [48:0] exp_q[$];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic        rd_pend = 1'b0;
  logic [15:0] rd_exp = 16'h0000;
  logic [48:0] ent;

  always @(negedge clk) begin
    if (rd_pend) begin
      check16("mdr_read_data", MDR, rd_exp);
      rd_pend = 1'b0;
    end
    if (R === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_R: got R=1 at cycle %0d expected no pending access", cyc);
      end else begin
        ent = exp_q.pop_front();
        n_checks++;
        if (cyc == int'(ent[48:17])) n_pass++;
        else $display("FAIL r_latency: got R at cycle %0d expected cycle %0d", cyc, int'(ent[48:17]));
        if (ent[16]) begin
          rd_pend = 1'b1;
          rd_exp  = ent[15:0];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic       clobber = 1'b0;
  logic       kb_on_acc = 1'b0;
  logic [7:0] kb_acc_char = 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [15:0] a, input logic we, input logic [15:0] d,
                        input logic [15:0] expd);
    logic got;
    bus = a; ldMAR = 1'b1; step(); ldMAR = 1'b0;
    if (we) begin
      bus = d; selMDR = 1'b0; ldMDR = 1'b1; step(); ldMDR = 1'b0;
    end
    memEN = 1'b1; memWE = we;
    exp_q.push_back({32'(cyc + W + 2), ~we, expd});
    step();
    memEN = 1'b0; memWE = 1'b0;
    if (clobber) begin
      bus = 16'hFFFF; ldMAR = 1'b1; ldMDR = 1'b1; selMDR = 1'b0;
      step();
      ldMAR = 1'b0; ldMDR = 1'b0;
    end
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (R) begin
        got = 1'b1;
        break;
      end
      if (kb_on_acc && n == W) begin
        kbData = kb_acc_char; kbStrobe = 1'b1;
      end
      step();
      kbStrobe = 1'b0;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL r_timeout: got no R for address %h expected R within 20 cycles", a);
    end
    if (!we) begin
      ldMDR = 1'b1; selMDR = 1'b1;
    end
    step();
    ldMDR = 1'b0; selMDR = 1'b0;
  endtask

  task automatic kb_strobe(input logic [7:0] c);
    kbData = c; kbStrobe = 1'b1; step(); kbStrobe = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int r_count;

  initial begin
    reset_n = 1'b0;
    step(); step();
    check16("reset_mar", MAR, 16'h0000);
    check16("reset_mdr", MDR, 16'h0000);
    check16("reset_r", {15'b0, R}, 16'h0000);
    check16("reset_disp_valid", {15'b0, dispValid}, 16'h0000);
    check16("reset_disp_data", {8'h00, dispData}, 16'h0000);
    check16("reset_state", 16'(dbg_state), 16'(IDLE));
    reset_n = 1'b1;
    step();

    // read with two wait states
    access(16'h0010, 1'b1, 16'hBEEF, 16'h0000);
    access(16'h0010, 1'b0, 16'h0000, 16'hBEEF);

    // write with MAR/MDR clobbered during WAIT, then read back
    clobber = 1'b1;
    access(16'h0020, 1'b1, 16'h1234, 16'h0000);
    clobber = 1'b0;
    check16("clobber_mar", MAR, 16'hFFFF);
    access(16'h0020, 1'b0, 16'h0000, 16'h1234);

    // keyboard
    kb_strobe(8'h41);
    access(16'hFE00, 1'b0, 16'h0000, 16'h8000);
    access(16'hFE02, 1'b0, 16'h0000, 16'h0041);
    access(16'hFE00, 1'b0, 16'h0000, 16'h0000);
    // strobe coinciding with the KBDR read edge
    kb_strobe(8'h42);
    kb_on_acc = 1'b1; kb_acc_char = 8'h43;
    access(16'hFE02, 1'b0, 16'h0000, 16'h0042);
    kb_on_acc = 1'b0;
    access(16'hFE00, 1'b0, 16'h0000, 16'h8000);
    access(16'hFE02, 1'b0, 16'h0000, 16'h0043);
    access(16'hFE00, 1'b0, 16'h0000, 16'h0000);

    // display
    dispReady = 1'b0;
    access(16'hFE06, 1'b1, 16'h0058, 16'h0000);
    check16("disp_valid_set", {15'b0, dispValid}, 16'h0001);
    check16("disp_data", {8'h00, dispData}, 16'h0058);
    access(16'hFE04, 1'b0, 16'h0000, 16'h0000);
    access(16'hFE06, 1'b0, 16'h0000, 16'h0058);
    dispReady = 1'b1; step(); dispReady = 1'b0;
    check16("disp_valid_clear", {15'b0, dispValid}, 16'h0000);
    access(16'hFE04, 1'b0, 16'h0000, 16'h8000);

    // unmapped address must not alias into RAM
    access(16'h0000, 1'b1, 16'h7777, 16'h0000);
    access(16'hC000, 1'b1, 16'hAAAA, 16'h0000);
    access(16'hC000, 1'b0, 16'h0000, 16'h0000);
    access(16'h0000, 1'b0, 16'h0000, 16'h7777);

    // reset in the middle of a write
    access(16'h0030, 1'b1, 16'h0000, 16'h0000);
    bus = 16'h0030; ldMAR = 1'b1; step(); ldMAR = 1'b0;
    bus = 16'h5555; ldMDR = 1'b1; selMDR = 1'b0; step(); ldMDR = 1'b0;
    memEN = 1'b1; memWE = 1'b1; step(); memEN = 1'b0; memWE = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check16("abort_mar", MAR, 16'h0000);
    check16("abort_mdr", MDR, 16'h0000);
    check16("abort_state", 16'(dbg_state), 16'(IDLE));
    step();
    reset_n = 1'b1;
    r_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (R) r_count++;
      step();
    end
    check16("abort_r_count", 16'(r_count), 16'h0000);
    access(16'h0030, 1'b0, 16'h0000, 16'h0000);

    // ---------------- report ----------------
    step(); step(); step();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_accesses: got %0d outstanding expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_memory_unit.md
# lc3_memory_unit

Memory-side responder for the LC-3 datapath: owns MAR and MDR, services the read/write requests that the control FSM issues, and raises the ready flag R when an access completes. It backs a word-addressed RAM plus the keyboard/display memory-mapped I/O registers. It sits between the control unit's load/enable strobes and the shared 16-bit bus.

## Interface
Parameters:
- MEM_DEPTH, 4096: RAM words, mapped at x0000..MEM_DEPTH-1; must be ≤ xFE00.
- WAIT_CYCLES, 2: extra wait states per access, 0..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bus  in  16  datapath bus value.
- ldMAR  in  1  MAR <- bus.
- ldMDR  in  1  MDR load strobe.
- selMDR  in  1  MDR source select: 1 = memory read data, 0 = bus.
- memEN  in  1  access request, sampled only in IDLE.
- memWE  in  1  access is a write, sampled with memEN.
- MAR  out  16  memory address register.
- MDR  out  16  memory data register.
- R  out  1  access-complete flag.
- kbData  in  8  keyboard character.
- kbStrobe  in  1  one-cycle pulse: kbData is valid.
- dispData  out  8  display character.
- dispValid  out  1  display character pending.
- dispReady  in  1  display consumer accepts dispData.

## Operation
- MAR and MDR are plain registers.
  - ldMAR loads MAR from bus.
  - ldMDR loads MDR from rdData when selMDR=1, otherwise from bus.
  - Both loads are honoured in any FSM state.
- Access FSM has three states: IDLE, WAIT and DONE.
  - IDLE goes to WAIT when memEN=1. On that edge, addr, wdata and the write flag are latched from MAR, MDR and memWE, and the wait counter is loaded with WAIT_CYCLES.
  - In WAIT, the counter decrements. When it reaches 0, the FSM goes to DONE, performs the access on that edge and sets R.
  - DONE always returns to IDLE. R is high for exactly one cycle, while the FSM is in DONE.
  - A memEN still high in IDLE after DONE starts a new access.
- Later changes to MAR, MDR or memWE have no effect on an access in flight.
- Address decode uses the latched addr:
  - Below MEM_DEPTH: RAM read or write.
  - xFE00 KBSR: reads {kbReady, 15'b0}; writes are ignored.
  - xFE02 KBDR: reads {8'h00, kbReg} and clears kbReady; writes are ignored.
  - xFE04 DSR: reads {~dispValid, 15'b0}; writes are ignored.
  - xFE06 DDR: a write sets dispData=wdata[7:0] and dispValid=1; a read returns {8'h00, dispData}.
  - Any other address: read returns x0000, write is dropped. R still asserts, so an unmapped access never hangs.
- rdData:
  - Updated on the access edge of a read.
  - Unchanged by a write access.
  - Holds its value until the next read completes.
- Keyboard:
  - kbStrobe loads kbReg from kbData and sets kbReady.
  - A strobe while kbReady is already set overwrites kbReg (overrun, no flag).
  - If a strobe and a KBDR read occur on the same edge, the read returns the old kbReg, the new character is stored, and kbReady stays 1.
- Display:
  - dispValid && dispReady clears dispValid.
  - A DDR write while dispValid is set overwrites dispData.
  - If a DDR write and the handshake occur on the same edge, the new data is stored and dispValid stays 1.

## Timing
- memEN is sampled high in IDLE on edge t; R is high during cycle t+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives R one cycle after the request.
- A RAM write commits on the same edge that raises R.
- Read data is valid in rdData while R is high, so the control unit can pulse ldMDR with selMDR=1 in the R cycle.
- Back-to-back accesses need at least WAIT_CYCLES+2 cycles each.
- Reset values:
  - MAR=0, MDR=0, rdData=0, R=0.
  - FSM in IDLE, counter 0.
  - kbReady=0, kbReg=0.
  - dispData=0, dispValid=0.
  - RAM contents are not reset.
- Reset mid-access aborts the access. A write not yet committed is lost, and R does not assert.

## Structure
- Shared package lc3_pkg holds:
  - The address constants KBSR_ADDR=xFE00, KBDR_ADDR=xFE02, DSR_ADDR=xFE04, DDR_ADDR=xFE06.
  - The FSM state enum {IDLE, WAIT, DONE}.
- One sub-module, lc3_mmio, holds the keyboard and display registers, their handshakes and the MMIO read mux.
- The RAM array and the access FSM live in the top level.

## Test plan
- Read, WAIT_CYCLES=2:
  - Stimulus: preload RAM[x0010]=xBEEF; ldMAR with bus=x0010; memEN=1, memWE=0 for one cycle.
  - Required: R high exactly 3 cycles later for one cycle; ldMDR with selMDR=1 in that cycle gives MDR=xBEEF.
- Write then read-back:
  - Stimulus: MAR=x0020, MDR=x1234 (selMDR=0); write access; then read x0020.
  - Required: rdData=x1234. Changing MDR during the write's WAIT does not alter the stored value.
- Keyboard:
  - Stimulus: kbStrobe with kbData=x41; read xFE00; read xFE02; read xFE00.
  - Required: reads return x8000, then x0041, then x0000. A strobe on the same edge as the KBDR read leaves KBSR=x8000.
- Display:
  - Stimulus: hold dispReady=0; write x0058 to xFE06.
  - Required: dispValid=1 and dispData=x58, DSR reads x0000. Raising dispReady for one cycle clears dispValid, and DSR then reads x8000.
- Unmapped address:
  - Stimulus: write and read xC000 with MEM_DEPTH=4096.
  - Required: R asserts for both, read returns x0000, RAM unchanged.
- Reset mid-access:
  - Stimulus: write x5555 to x0030 (RAM initially x0000); drop reset_n during WAIT.
  - Required: R never asserts; MAR=MDR=0; RAM[x0030] still x0000.
